// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA horizontal timing defaults, derived constants and FSM encoding.
package vga_timing_pkg;
   typedef enum logic [1:0] {SYNC, BACK_PORCH, DISPLAY, FRONT_PORCH} h_state_t;
   localparam int H_SYNC       = 384;
   localparam int H_BP         = 192;
   localparam int H_DISP       = 2560;
   localparam int H_FP         = 64;
   localparam int SUB_DIV      = 20;
   localparam int H_TOTAL      = H_SYNC + H_BP + H_DISP + H_FP;
   localparam int H_DISP_START = H_SYNC + H_BP;
   localparam int H_DISP_END   = H_DISP_START + H_DISP - 1;
endpackage

// File: rtl/sub_pixel_div.sv
// sub_pixel_div: mod-DIV counter with synchronous clear (clear wins over enable).
module sub_pixel_div #(
   parameter int DIV = 20,
   parameter int W   = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clr) count <= '0;
      else if (en) count <= (count == W'(DIV - 1)) ? '0 : count + W'(1);
endmodule

// File: rtl/hsync_gen.sv
// hsync_gen: horizontal VGA timing generator (H_count, HSYNC, display window, sub-pixel divider).
// Optional line_done strobe on the last tick of a line is built when HSYNC_GEN_LINE_STROBE_EN is defined.
module hsync_gen #(
   parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
   parameter int H_BP    = vga_timing_pkg::H_BP,
   parameter int H_DISP  = vga_timing_pkg::H_DISP,
   parameter int H_FP    = vga_timing_pkg::H_FP,
   parameter int SUB_DIV = vga_timing_pkg::SUB_DIV
) (
   input  logic        clk,
   input  logic        reset,
   output logic [11:0] H_count,
   output logic        HSYNC,
   output logic [4:0]  five_count_hor,
`ifdef HSYNC_GEN_LINE_STROBE_EN
   output logic        line_done,
`endif
   output logic        h_display
);
   import vga_timing_pkg::*;
   localparam int LINE_LEN = H_SYNC + H_BP + H_DISP + H_FP;
   localparam logic [11:0] SYNC_END = 12'(H_SYNC - 1);
   localparam logic [11:0] BP_END   = 12'(H_SYNC + H_BP - 1);
   localparam logic [11:0] DISP_END = 12'(H_SYNC + H_BP + H_DISP - 1);
   localparam logic [11:0] LAST     = 12'(LINE_LEN - 1);
   h_state_t state, nxt_state;
   logic [11:0] nxt_count;
   always_comb begin
      nxt_count = (H_count == LAST) ? 12'd0 : H_count + 12'd1;
      nxt_state = (state == SYNC        && H_count == SYNC_END) ? BACK_PORCH  :
                  (state == BACK_PORCH  && H_count == BP_END)   ? DISPLAY     :
                  (state == DISPLAY     && H_count == DISP_END) ? FRONT_PORCH :
                  (state == FRONT_PORCH && H_count == LAST)     ? SYNC        : state;
   end
   // Outputs are registered from the next-state so they line up with the H_count they describe.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         H_count   <= 12'd0;
         state     <= SYNC;
         HSYNC     <= 1'b0;
         h_display <= 1'b0;
      end else begin
         H_count   <= nxt_count;
         state     <= nxt_state;
         HSYNC     <= nxt_state != SYNC;
         h_display <= nxt_state == DISPLAY;
      end
`ifdef HSYNC_GEN_LINE_STROBE_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) line_done <= 1'b0;
      else line_done <= nxt_count == LAST;
`endif
   sub_pixel_div #(.DIV(SUB_DIV), .W(5)) u_div (
      .clk   (clk),
      .reset (reset),
      .clr   (nxt_state != DISPLAY),
      .en    (state == DISPLAY),
      .count (five_count_hor)
   );
   legal_params: assert property (@(posedge clk) LINE_LEN <= 4096 && (H_DISP % SUB_DIV) == 0);
endmodule

// File: tb/tb_hsync_gen.sv
// tb_hsync_gen: randomized reset stimulus checked every cycle against an arithmetic line-position model.
module tb_hsync_gen;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] H_count;
   logic        HSYNC;
   logic        h_display;
   logic [4:0]  five_count_hor;
`ifdef HSYNC_GEN_LINE_STROBE_EN
   logic        line_done;
   int          last_ld = -1;
`endif
   int checks = 0, failures = 0;
   int mh = 0;
   int cyc = 0, prev_h = -1, lo, dsp, ev, first_ev, last_ev;
   bit full = 1'b0;

   always #5 clk = ~clk;

   hsync_gen dut (
      .clk            (clk),
      .reset          (reset),
      .H_count        (H_count),
      .HSYNC          (HSYNC),
      .five_count_hor (five_count_hor),
`ifdef HSYNC_GEN_LINE_STROBE_EN
      .line_done      (line_done),
`endif
      .h_display      (h_display)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (H_count=%0d, cycle %0d)", name, act, exp, H_count, cyc);
      end
   endtask

   // Model: position within the line is just clocks since reset, modulo the line length.
   always @(posedge clk or posedge reset)
      mh <= reset ? 0 : (mh + 1) % 3200;

   always @(negedge clk) begin
      int h;
      bit in_disp;
      h = mh;
      in_disp = h >= 576 && h <= 3135;
      cyc++;
      chk("h_count", int'(H_count), h);
      chk("hsync", int'(HSYNC), int'(h >= 384));
      chk("h_display", int'(h_display), int'(in_disp));
      chk("five_count_hor", int'(five_count_hor), in_disp ? (h - 576) % 20 : 0);
`ifdef HSYNC_GEN_LINE_STROBE_EN
      chk("line_done", int'(line_done), int'(h == 3199));
      if (reset) last_ld = -1;
      else if (line_done) begin
         if (last_ld >= 0) chk("line_done_period", cyc - last_ld, 3200);
         last_ld = cyc;
      end
`endif
      if (reset) begin
         full = 1'b0;
         prev_h = -1;
      end else begin
         if (prev_h == 3199) begin
            chk("wrap_h_count", int'(H_count), 0);
            chk("wrap_hsync", int'(HSYNC), 0);
         end
         if (H_count == 12'd575 || H_count == 12'd3136) chk("five_edge_zero", int'(five_count_hor), 0);
         if (H_count == 12'd0) begin
            full = 1'b1; lo = 0; dsp = 0; ev = 0; first_ev = -1; last_ev = -1;
         end
         if (full) begin
            lo += int'(!HSYNC);
            dsp += int'(h_display);
            if (five_count_hor == 5'd19) begin
               ev++;
               if (first_ev < 0) first_ev = int'(H_count);
               last_ev = int'(H_count);
            end
            if (H_count == 12'd3199) begin
               chk("hsync_low_clocks", lo, 384);
               chk("display_clocks", dsp, 2560);
               chk("terminal_count_events", ev, 128);
               chk("first_terminal", first_ev, 595);
               chk("last_terminal", last_ev, 3135);
            end
         end
         prev_h = int'(H_count);
      end
   end

   task automatic mid_reset(input int at);
      int n = 0;
      if (at >= 0) begin
         while (int'(H_count) != at && n < 4000) begin
            @(negedge clk);
            n++;
         end
         chk("reach_target", int'(H_count), at);
         chk("target_in_display", int'(h_display), 1);
      end
      #($urandom_range(1, 3));
      reset = 1'b1;
      #1;
      chk("async_h_count", int'(H_count), 0);
      chk("async_hsync", int'(HSYNC), 0);
      chk("async_h_display", int'(h_display), 0);
      chk("async_five", int'(five_count_hor), 0);
`ifdef HSYNC_GEN_LINE_STROBE_EN
      chk("async_line_done", int'(line_done), 0);
`endif
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      repeat (10) @(negedge clk);
      chk("reset_h_count", int'(H_count), 0);
      chk("reset_hsync", int'(HSYNC), 0);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("first_step", int'(H_count), 1);
      @(negedge clk);
      chk("second_step", int'(H_count), 2);
      repeat (4 * 3200) @(negedge clk);
      mid_reset(1000);
      repeat (3300) @(negedge clk);
      repeat (5) begin
         repeat ($urandom_range(50, 4000)) @(negedge clk);
         mid_reset(-1);
      end
      repeat (3300) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
